// File: rtl/cursor_step_scheduler.sv
// cursor_step_scheduler: turns the four raw push-buttons into per-axis one-cycle step strobes.
// Each button is synchronised and debounced. An immediate step is followed by a hold-off and
// then auto-repeat. The optional acceleration stage is built only when CURSOR_ACCEL_EN is defined.
module cursor_step_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY       = 25000000,
    parameter int unsigned REPEAT_PERIOD_SLOW = 2500000,
    parameter int unsigned REPEAT_PERIOD_FAST = 500000,
    parameter int unsigned ACCEL_STEPS        = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_east,
    input  logic btn_west,
    input  logic btn_north,
    input  logic btn_south,
    output logic step_x_inc,
    output logic step_x_dec,
    output logic step_y_inc,
    output logic step_y_dec,
    output logic moving,
    output logic fast
);

    // Button bit positions inside the packed button vectors.
    localparam int BtnEast  = 0;
    localparam int BtnWest  = 1;
    localparam int BtnNorth = 2;
    localparam int BtnSouth = 3;

    // Debounce counter only ever has to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

    localparam logic [31:0] DelayLoad = 32'(REPEAT_DELAY);
    localparam logic [31:0] SlowLoad  = 32'(REPEAT_PERIOD_SLOW);

`ifdef CURSOR_ACCEL_EN
    localparam int unsigned RepW = (ACCEL_STEPS > 0) ? $clog2(ACCEL_STEPS + 1) : 1;
    localparam logic [RepW-1:0] AccelMax = RepW'(ACCEL_STEPS);
    localparam logic [31:0]     FastLoad = 32'(REPEAT_PERIOD_FAST);
`endif

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_DELAY == 0 || REPEAT_PERIOD_SLOW == 0 || REPEAT_PERIOD_FAST == 0) begin : g_bad_ivl
        $error("repeat intervals must be at least 1");
    end
    if (REPEAT_PERIOD_FAST > REPEAT_PERIOD_SLOW) begin : g_bad_fast
        $error("REPEAT_PERIOD_FAST must not exceed REPEAT_PERIOD_SLOW");
    end
    if (ACCEL_STEPS == 0) begin : g_bad_accel
        $error("ACCEL_STEPS must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } state_e;

    logic [3:0]          btn_raw;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          deb_q, deb_d;
    logic [3:0][DbW-1:0] db_cnt_q, db_cnt_d;

    // Direction vector / strobe bit order: {y_dec, y_inc, x_dec, x_inc}.
    logic [3:0]  vec;
    logic        vec_active;
    logic        running;
    logic        expire;

    state_e      state_q, state_d;
    logic [31:0] ivl_q, ivl_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  step_q, step_d;

`ifdef CURSOR_ACCEL_EN
    logic [RepW-1:0] rep_q, rep_d, rep_nx;
    logic            fast_q, fast_d;
`endif

    assign btn_raw = {btn_south, btn_north, btn_west, btn_east};

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounced level and run-length counter registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            deb_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Opposing buttons on one axis cancel each other.
    assign vec = {deb_q[BtnNorth] & ~deb_q[BtnSouth],
                  deb_q[BtnSouth] & ~deb_q[BtnNorth],
                  deb_q[BtnWest]  & ~deb_q[BtnEast],
                  deb_q[BtnEast]  & ~deb_q[BtnWest]};

    assign vec_active = |vec;
    assign running    = (state_q == StDelay) || (state_q == StRepeat);
    assign expire     = (ivl_q <= 32'd1);

    // Schedule next state: immediate step, hold-off, then auto-repeat.
    always_comb begin
        state_d = state_q;
        ivl_d   = ivl_q;
        vec_d   = vec_q;
        step_d  = '0;
`ifdef CURSOR_ACCEL_EN
        rep_d   = rep_q;
        rep_nx  = rep_q;
        fast_d  = fast_q;
`endif
        if (!vec_active) begin
            state_d = StIdle;
            ivl_d   = '0;
            vec_d   = '0;
`ifdef CURSOR_ACCEL_EN
            rep_d   = '0;
            fast_d  = 1'b0;
`endif
        end else if (!running || (vec != vec_q)) begin
            // New press or changed direction wins over a coincident expiry.
            state_d = StDelay;
            step_d  = vec;
            vec_d   = vec;
            ivl_d   = DelayLoad;
`ifdef CURSOR_ACCEL_EN
            rep_d   = '0;
            fast_d  = 1'b0;
`endif
        end else if (expire) begin
            state_d = StRepeat;
            step_d  = vec;
`ifdef CURSOR_ACCEL_EN
            if (state_q == StDelay) begin
                rep_nx = RepW'(1);
            end else if (rep_q < AccelMax) begin
                rep_nx = rep_q + 1'b1;
            end
            rep_d  = rep_nx;
            fast_d = (rep_nx >= AccelMax);
            ivl_d  = (rep_nx >= AccelMax) ? FastLoad : SlowLoad;
`else
            ivl_d  = SlowLoad;
`endif
        end else begin
            ivl_d = ivl_q - 32'd1;
        end
    end

    // FSM, interval counter and registered strobe outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            ivl_q   <= '0;
            vec_q   <= '0;
            step_q  <= '0;
`ifdef CURSOR_ACCEL_EN
            rep_q   <= '0;
            fast_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ivl_q   <= ivl_d;
            vec_q   <= vec_d;
            step_q  <= step_d;
`ifdef CURSOR_ACCEL_EN
            rep_q   <= rep_d;
            fast_q  <= fast_d;
`endif
        end
    end

    assign step_x_inc = step_q[0];
    assign step_x_dec = step_q[1];
    assign step_y_inc = step_q[2];
    assign step_y_dec = step_q[3];
    assign moving     = (state_q != StIdle);

`ifdef CURSOR_ACCEL_EN
    assign fast = fast_q;
`else
    assign fast = 1'b0;
`endif

endmodule
